// File: rtl/rr_grant_arb8_pkg.sv
// Shared definitions for the eight-way round-robin grant arbiter.
package arb_pkg;

  localparam int unsigned ARB_N = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Advance a 3-bit priority pointer; 7 wraps to 0.
  function automatic logic [2:0] inc_mod8(input logic [2:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/rr_grant_arb8_pick.sv
// Rotating-priority pick: first set request at or after ptr, wrapping 7->0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [2:0]       ptr,
  output logic [ARB_N-1:0] win_onehot,
  output logic             any_req
);

  logic [2:0] idx;
  logic       found;

  // Walk the request lines from ptr upward and keep only the first hit.
  always_comb begin
    win_onehot = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < ARB_N; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        win_onehot[idx] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_grant_arb8.sv
// Eight-way round-robin arbiter with bounded hold and a mandatory idle
// cycle between grants; all outputs come straight from flops.
module rr_grant_arb8
  import arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [7:0]   hold_cnt
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t         state;
  logic [2:0]     ptr;
  logic [N-1:0]   win_onehot;
  logic           any_req;
  logic [2:0]     win_idx;
  logic           keep;

  rr_pick u_pick (
    .req        (req),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .any_req    (any_req)
  );

  // Encode the one-hot winner so the pointer can move just past it.
  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win_onehot[k]) win_idx = 3'(k);
    end
  end

  // Holder keeps the grant while it still requests and is under the limit.
  always_comb begin
    keep = (|(req & grant)) && (hold_cnt != HOLD_LIM);
  end

  // Arbiter FSM; every release passes through IDLE for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= BUSY;
            grant       <= win_onehot;
            grant_valid <= 1'b1;
            hold_cnt    <= 8'd1;
            ptr         <= inc_mod8(win_idx);
          end
        end
        BUSY: begin
          if (keep) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arb8.sv
// Bench for rr_grant_arb8: two instances (hold limits 16 and 2) checked
// every cycle against an integer model, plus directed literal checks.
module tb_rr_grant_arb8;

  typedef struct packed {
    int cur;   // granted requester, -1 when idle
    int hold;
    int ptr;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic [7:0] grant_w [2];
  logic       valid_w [2];
  logic [7:0] hold_w  [2];
  logic [7:0] prev_g  [2];

  int unsigned checks = 0;
  int unsigned passed = 0;
  int          lim [2] = '{16, 2};
  mstate_t     m_st [2];

  always #5 clk = ~clk;

  rr_grant_arb8 #(.N(8), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_w[0]), .grant_valid(valid_w[0]), .hold_cnt(hold_w[0])
  );

  rr_grant_arb8 #(.N(8), .MAX_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .grant(grant_w[1]), .grant_valid(valid_w[1]), .hold_cnt(hold_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic mstate_t step(input mstate_t s, input int l, input logic [7:0] r);
    mstate_t n = s;
    if (s.cur < 0) begin
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (s.ptr + k) % 8;
        if (n.cur < 0 && r[j]) begin
          n.cur  = j;
          n.hold = 1;
          n.ptr  = (j + 1) % 8;
        end
      end
    end else if (!r[s.cur] || s.hold >= l) begin
      n.cur  = -1;
      n.hold = 0;
    end else begin
      n.hold = s.hold + 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_grant(input int cur);
    logic [7:0] g = '0;
    if (cur >= 0) g[cur] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) m_st[i] <= '{cur: -1, hold: 0, ptr: 0};
      else     m_st[i] <= step(m_st[i], lim[i], req);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("grant%0d", i), 32'(grant_w[i]), 32'(exp_grant(m_st[i].cur)));
      chk($sformatf("valid%0d", i), 32'(valid_w[i]), 32'(m_st[i].cur >= 0));
      chk($sformatf("hold%0d", i), 32'(hold_w[i]), 32'(m_st[i].hold));
      chk($sformatf("onehot%0d", i), 32'($countones(grant_w[i]) <= 1), 32'd1);
      chk($sformatf("validor%0d", i), 32'(valid_w[i]), 32'(|grant_w[i]));
      chk($sformatf("holdmax%0d", i), 32'(int'(hold_w[i]) <= lim[i]), 32'd1);
      chk($sformatf("gap%0d", i),
          32'(prev_g[i] != 8'h00 && grant_w[i] != 8'h00 && grant_w[i] != prev_g[i]), 32'd0);
      prev_g[i] <= grant_w[i];
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    prev_g[0] = '0;
    prev_g[1] = '0;
    m_st[0] = '{cur: -1, hold: 0, ptr: 0};
    m_st[1] = '{cur: -1, hold: 0, ptr: 0};

    // Reset state, then no requests for five cycles.
    reset_dut();
    chk("rst_grant", 32'(grant_w[0]), 32'h0);
    chk("rst_valid", 32'(valid_w[0]), 32'h0);
    chk("rst_hold",  32'(hold_w[0]),  32'h0);
    repeat (5) begin
      @(negedge clk);
      chk("idle_grant", 32'(grant_w[0]), 32'h0);
    end

    // req=81 held: 01 for 16 cycles, bubble, 80 for 16, bubble, 01 again.
    reset_dut();
    req = 8'h81;
    @(negedge clk);
    chk("h81_first", 32'(grant_w[0]), 32'h01);
    chk("h81_hold1", 32'(hold_w[0]), 32'd1);
    repeat (15) @(negedge clk);
    chk("h81_g16", 32'(grant_w[0]), 32'h01);
    chk("h81_h16", 32'(hold_w[0]), 32'd16);
    @(negedge clk);
    chk("h81_bub1", 32'(grant_w[0]), 32'h0);
    @(negedge clk);
    chk("h81_second", 32'(grant_w[0]), 32'h80);
    repeat (16) @(negedge clk);
    chk("h81_bub2", 32'(grant_w[0]), 32'h0);
    @(negedge clk);
    chk("h81_third", 32'(grant_w[0]), 32'h01);

    // req=FF with limit 2: each bit for two cycles, then one idle cycle.
    reset_dut();
    req = 8'hFF;
    for (int e = 0; e < 26; e++) begin
      logic [7:0] exp;
      exp = '0;
      @(negedge clk);
      if (e % 3 < 2) exp[(e / 3) % 8] = 1'b1;
      chk("rot_ff", 32'(grant_w[1]), 32'(exp));
    end

    // Early release of 04 at hold 3, then 0C picks 08 (ptr=3).
    reset_dut();
    req = 8'h04;
    repeat (3) @(negedge clk);
    chk("drop_g", 32'(grant_w[0]), 32'h04);
    chk("drop_h", 32'(hold_w[0]), 32'd3);
    req = 8'h00;
    @(negedge clk);
    chk("drop_rel", 32'(grant_w[0]), 32'h0);
    req = 8'h0C;
    @(negedge clk);
    chk("drop_next", 32'(grant_w[0]), 32'h08);

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    reset_dut();
    req = 8'h20;
    repeat (5) @(negedge clk);
    chk("ar_g", 32'(grant_w[0]), 32'h20);
    chk("ar_h", 32'(hold_w[0]), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("ar_grant", 32'(grant_w[0]), 32'h0);
    chk("ar_valid", 32'(valid_w[0]), 32'h0);
    chk("ar_hold",  32'(hold_w[0]),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h21;
    @(negedge clk);
    chk("ar_ptr0", 32'(grant_w[0]), 32'h01);

    // Random traffic, checked every cycle by the compare process.
    repeat (10000) begin
      @(negedge clk);
      req = 8'($urandom) & 8'($urandom);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
